// File: rtl/fifo_sync_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_sync_ctrl_pkg
// Description : Shared RAM/FIFO geometry used by the FIFO controller slice.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_sync_ctrl_pkg;

    // Shared geometry of the dual-port SRAM that the FIFO drives.
    localparam int a_length     = 3;
    localparam int d_length     = 8;
    localparam int config_depth = 8;

endpackage : fifo_sync_ctrl_pkg
`default_nettype wire

// File: rtl/fifo_sync_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_sync_ctrl_if
// Description : Dual-port SRAM bus (port 1 write, port 2 read) between the
//               FIFO controller (master) and the RAM (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_sync_ctrl_if
    import fifo_sync_ctrl_pkg::*;
#(
    parameter int A_LENGTH = a_length,
    parameter int D_LENGTH = d_length
) ();

    logic                ram_en_w;
    logic                ram_ctrl_w;
    logic [A_LENGTH-1:0] ram_addr_w;
    logic [D_LENGTH-1:0] ram_wdata;
    logic                ram_en_r;
    logic                ram_ctrl_r;
    logic [A_LENGTH-1:0] ram_addr_r;
    logic [D_LENGTH-1:0] ram_rdata;

    modport master (
        output ram_en_w, ram_ctrl_w, ram_addr_w, ram_wdata,
        output ram_en_r, ram_ctrl_r, ram_addr_r,
        input  ram_rdata
    );

    modport slave (
        input  ram_en_w, ram_ctrl_w, ram_addr_w, ram_wdata,
        input  ram_en_r, ram_ctrl_r, ram_addr_r,
        output ram_rdata
    );

endinterface : fifo_sync_ctrl_if
`default_nettype wire

// File: rtl/fifo_sync_ctrl_ptr_flag.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ptr_flag
// Description : Circular-buffer pointers, occupancy count and registered
//               status flags for the synchronous FIFO controller.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_ptr_flag
    import fifo_sync_ctrl_pkg::*;
#(
    parameter int A_LENGTH = a_length,
    parameter int DEPTH    = config_depth
) (
    input  wire logic                clk,
    input  wire logic                rst_n,
    input  wire logic                wr_acc,
    input  wire logic                rd_acc,
    output logic      [A_LENGTH-1:0] wr_ptr,
    output logic      [A_LENGTH-1:0] rd_ptr,
    output logic      [A_LENGTH:0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty
);

    localparam logic [A_LENGTH-1:0] c_ptr_last = A_LENGTH'(DEPTH - 1);
    localparam logic [A_LENGTH-1:0] c_ptr_one  = A_LENGTH'(1);
    localparam logic [A_LENGTH:0]   c_cnt_full = (A_LENGTH + 1)'(DEPTH);
    localparam logic [A_LENGTH:0]   c_cnt_af   = (A_LENGTH + 1)'(DEPTH - 1);
    localparam logic [A_LENGTH:0]   c_cnt_one  = (A_LENGTH + 1)'(1);

    logic [A_LENGTH-1:0] r_wr_ptr, r_rd_ptr;
    logic [A_LENGTH-1:0] w_wr_ptr_nxt, w_rd_ptr_nxt;
    logic [A_LENGTH:0]   r_count, w_count_nxt;
    logic                r_full, r_empty, r_almost_full, r_almost_empty;

    // Wrap by explicit compare so non-power-of-2 depths work.
    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_count_nxt  = r_count;
        if (wr_acc) begin
            w_wr_ptr_nxt = (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + c_ptr_one;
        end
        if (rd_acc) begin
            w_rd_ptr_nxt = (r_rd_ptr == c_ptr_last) ? '0 : r_rd_ptr + c_ptr_one;
        end
        case ({wr_acc, rd_acc})
            2'b10:   w_count_nxt = r_count + c_cnt_one;
            2'b01:   w_count_nxt = r_count - c_cnt_one;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
        end else begin
            r_wr_ptr       <= w_wr_ptr_nxt;
            r_rd_ptr       <= w_rd_ptr_nxt;
            r_count        <= w_count_nxt;
            r_full         <= (w_count_nxt == c_cnt_full);
            r_empty        <= (w_count_nxt == '0);
            r_almost_full  <= (w_count_nxt >= c_cnt_af);
            r_almost_empty <= (w_count_nxt <= c_cnt_one);
        end
    end

    assign wr_ptr       = r_wr_ptr;
    assign rd_ptr       = r_rd_ptr;
    assign count        = r_count;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;

endmodule : fifo_ptr_flag
`default_nettype wire

// File: rtl/fifo_sync_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fifo_sync_ctrl
// Description : Single-clock FIFO controller driving an external dual-port
//               SRAM as a circular buffer with registered-output reads.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_sync_ctrl
    import fifo_sync_ctrl_pkg::*;
#(
    parameter int A_LENGTH = a_length,
    parameter int D_LENGTH = d_length,
    parameter int DEPTH    = config_depth
) (
    input  wire logic                clk,
    input  wire logic                rst_n,
    input  wire logic                wr_en,
    input  wire logic [D_LENGTH-1:0] wr_data,
    input  wire logic                rd_en,
    output logic      [D_LENGTH-1:0] rd_data,
    output logic                     rd_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic      [A_LENGTH:0]   count,
    output logic                     overflow,
    output logic                     underflow,
    fifo_sync_ctrl_if.master         ram
);

    logic                w_wr_acc, w_rd_acc;
    logic [A_LENGTH-1:0] w_wr_ptr, w_rd_ptr;
    logic                r_rd_valid, r_overflow, r_underflow;

    // A write at full is still taken when a read frees the same slot.
    assign w_wr_acc = wr_en & (~full | rd_en);
    assign w_rd_acc = rd_en & ~empty;

    fifo_ptr_flag #(
        .A_LENGTH (A_LENGTH),
        .DEPTH    (DEPTH)
    ) u_ptr_flag (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_acc       (w_wr_acc),
        .rd_acc       (w_rd_acc),
        .wr_ptr       (w_wr_ptr),
        .rd_ptr       (w_rd_ptr),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
    );

    assign ram.ram_en_w   = w_wr_acc;
    assign ram.ram_ctrl_w = 1'b1;
    assign ram.ram_addr_w = w_wr_ptr;
    assign ram.ram_wdata  = wr_data;
    assign ram.ram_en_r   = w_rd_acc;
    assign ram.ram_ctrl_r = 1'b0;
    assign ram.ram_addr_r = w_rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_rd_valid  <= w_rd_acc;
            r_overflow  <= wr_en & ~w_wr_acc;
            r_underflow <= rd_en & ~w_rd_acc;
        end
    end

    assign rd_data   = ram.ram_rdata;
    assign rd_valid  = r_rd_valid;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule : fifo_sync_ctrl
`default_nettype wire

// File: tb/tb_fifo_sync_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_sync_ctrl
// Description : Self-checking bench for fifo_sync_ctrl with a behavioural
//               SRAM and a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_sync_ctrl;

    localparam int AW    = 3;
    localparam int DW    = 8;
    localparam int DEPTH = 8;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          wr_en   = 1'b0;
    logic          rd_en   = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] rd_data;
    logic          rd_valid, full, empty, almost_full, almost_empty;
    logic          overflow, underflow;
    logic [AW:0]   count;

    fifo_sync_ctrl_if #(.A_LENGTH(AW), .D_LENGTH(DW)) ram_if ();

    fifo_sync_ctrl #(
        .A_LENGTH (AW),
        .D_LENGTH (DW),
        .DEPTH    (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .ram          (ram_if)
    );

    always #5 clk = ~clk;

    // Behavioural dual-port SRAM with registered port-2 output.
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] ram_q;
    always @(posedge clk) begin
        if (ram_if.ram_en_w && ram_if.ram_ctrl_w) mem[ram_if.ram_addr_w] <= ram_if.ram_wdata;
        if (ram_if.ram_en_r && !ram_if.ram_ctrl_r) ram_q <= mem[ram_if.ram_addr_r];
    end
    assign ram_if.ram_rdata = ram_q;

    // Reference model: a queue of stored words plus slot indices.
    logic [DW-1:0] q[$];
    int            wr_idx, rd_idx, p_waddr, p_raddr;
    bit            p_wacc, p_racc, exp_valid, exp_ovf, exp_udf;
    logic [DW-1:0] exp_data;
    int            n_checks = 0;
    int            n_errors = 0;

    task automatic model_reset();
        q.delete();
        wr_idx = 0; rd_idx = 0;
        exp_valid = 1'b0; exp_ovf = 1'b0; exp_udf = 1'b0;
    endtask

    task automatic drive(input bit w, input logic [DW-1:0] d, input bit r);
        wr_en = w; wr_data = d; rd_en = r;
        p_wacc  = w && (q.size() < DEPTH || r);
        p_racc  = r && (q.size() > 0);
        p_waddr = wr_idx;
        p_raddr = rd_idx;
    endtask

    task automatic tick();
        @(posedge clk);
        if (p_racc) begin
            exp_data = q.pop_front();
            rd_idx   = (rd_idx + 1) % DEPTH;
        end
        if (p_wacc) begin
            q.push_back(wr_data);
            wr_idx = (wr_idx + 1) % DEPTH;
        end
        exp_valid = p_racc;
        exp_ovf   = wr_en && !p_wacc;
        exp_udf   = rd_en && !p_racc;
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, '0, 1'b0);
        #1;
        n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL reset_empty got %0b exp 1", empty); end
        n_checks++; if (almost_empty !== 1'b1) begin n_errors++; $display("FAIL reset_aempty got %0b exp 1", almost_empty); end
        n_checks++; if (count !== '0) begin n_errors++; $display("FAIL reset_count got %0d exp 0", count); end
        n_checks++; if (rd_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %0b exp 0", rd_valid); end
        n_checks++; if ({full, almost_full, overflow, underflow} !== 4'b0) begin n_errors++; $display("FAIL reset_flags got %0b exp 0", {full, almost_full, overflow, underflow}); end
        n_checks++; if ({ram_if.ram_en_w, ram_if.ram_en_r} !== 2'b00) begin n_errors++; $display("FAIL reset_ram_en got %0b exp 0", {ram_if.ram_en_w, ram_if.ram_en_r}); end
        tick();
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 8'(8'h10 + i), 1'b0);
            tick();
            n_checks++; if (count !== (AW+1)'(i + 1)) begin n_errors++; $display("FAIL fill_count got %0d exp %0d", count, i + 1); end
            n_checks++; if (almost_full !== (i + 1 >= DEPTH - 1)) begin n_errors++; $display("FAIL fill_afull got %0b at count %0d", almost_full, i + 1); end
            n_checks++; if (full !== (i + 1 == DEPTH)) begin n_errors++; $display("FAIL fill_full got %0b at count %0d", full, i + 1); end
        end
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, '0, 1'b1);
            tick();
            n_checks++; if (rd_valid !== 1'b1) begin n_errors++; $display("FAIL drain_valid got %0b exp 1", rd_valid); end
            n_checks++; if (rd_data !== 8'(8'h10 + i) || rd_data !== exp_data) begin n_errors++; $display("FAIL drain_data got %0h exp %0h", rd_data, 8'(8'h10 + i)); end
        end
        drive(1'b0, '0, 1'b0);
        tick();
        n_checks++; if (rd_valid !== 1'b0) begin n_errors++; $display("FAIL drain_valid_drop got %0b exp 0", rd_valid); end
        n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL drain_empty got %0b exp 1", empty); end
    endtask

    task automatic test_overflow_underflow();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 8'($urandom_range(0, 8'hA9)), 1'b0);
            tick();
        end
        drive(1'b1, 8'hAA, 1'b0);
        tick();
        n_checks++; if (overflow !== 1'b1 || overflow !== exp_ovf) begin n_errors++; $display("FAIL ovf_pulse got %0b exp 1", overflow); end
        n_checks++; if (count !== (AW+1)'(DEPTH)) begin n_errors++; $display("FAIL ovf_count got %0d exp %0d", count, DEPTH); end
        drive(1'b0, '0, 1'b0);
        tick();
        n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL ovf_one_cycle got %0b exp 0", overflow); end
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, '0, 1'b1);
            tick();
            n_checks++; if (rd_data !== exp_data || rd_data === 8'hAA) begin n_errors++; $display("FAIL ovf_drain got %0h exp %0h", rd_data, exp_data); end
        end
        drive(1'b0, '0, 1'b1);
        tick();
        n_checks++; if (underflow !== 1'b1 || underflow !== exp_udf) begin n_errors++; $display("FAIL udf_pulse got %0b exp 1", underflow); end
        n_checks++; if (rd_valid !== 1'b0) begin n_errors++; $display("FAIL udf_valid got %0b exp 0", rd_valid); end
        drive(1'b0, '0, 1'b0);
        tick();
        n_checks++; if (underflow !== 1'b0) begin n_errors++; $display("FAIL udf_one_cycle got %0b exp 0", underflow); end
    endtask

    task automatic test_simultaneous();
        logic [DW-1:0] last;
        last = '0;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 8'($urandom_range(0, 8'h54)), 1'b0);
            tick();
        end
        drive(1'b1, 8'h55, 1'b1);
        #1;
        n_checks++; if ({ram_if.ram_en_w, ram_if.ram_en_r} !== 2'b11) begin n_errors++; $display("FAIL full_both_en got %0b exp 11", {ram_if.ram_en_w, ram_if.ram_en_r}); end
        n_checks++; if (ram_if.ram_addr_w !== ram_if.ram_addr_r) begin n_errors++; $display("FAIL full_both_addr got %0d exp %0d", ram_if.ram_addr_w, ram_if.ram_addr_r); end
        tick();
        n_checks++; if (rd_valid !== 1'b1 || rd_data !== exp_data) begin n_errors++; $display("FAIL full_both_data got %0h exp %0h", rd_data, exp_data); end
        n_checks++; if (count !== (AW+1)'(DEPTH) || overflow !== 1'b0) begin n_errors++; $display("FAIL full_both_count got %0d exp %0d", count, DEPTH); end
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, '0, 1'b1);
            tick();
            last = rd_data;
            n_checks++; if (rd_data !== exp_data) begin n_errors++; $display("FAIL full_both_drain got %0h exp %0h", rd_data, exp_data); end
        end
        n_checks++; if (last !== 8'h55) begin n_errors++; $display("FAIL full_both_last got %0h exp 55", last); end
        drive(1'b1, 8'h66, 1'b1);
        tick();
        n_checks++; if (count !== (AW+1)'(1)) begin n_errors++; $display("FAIL empty_both_count got %0d exp 1", count); end
        n_checks++; if (underflow !== 1'b1 || rd_valid !== 1'b0) begin n_errors++; $display("FAIL empty_both_udf got %0b/%0b exp 1/0", underflow, rd_valid); end
        drive(1'b0, '0, 1'b1);
        tick();
        n_checks++; if (rd_valid !== 1'b1 || rd_data !== 8'h66) begin n_errors++; $display("FAIL empty_both_read got %0h exp 66", rd_data); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 8'(i), i > 0);
            #1;
            n_checks++; if (ram_if.ram_addr_w !== AW'(p_waddr)) begin n_errors++; $display("FAIL wrap_waddr got %0d exp %0d", ram_if.ram_addr_w, p_waddr); end
            tick();
            if (i > 0) begin
                n_checks++; if (rd_valid !== 1'b1 || rd_data !== 8'(i - 1)) begin n_errors++; $display("FAIL wrap_data got %0h exp %0h", rd_data, i - 1); end
            end
        end
        drive(1'b0, '0, 1'b1);
        tick();
        n_checks++; if (rd_data !== 8'h13 || empty !== 1'b1) begin n_errors++; $display("FAIL wrap_last got %0h exp 13", rd_data); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            int pw;
            pw = (n < 200) ? 65 : 35;
            drive($urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) < 50);
            #1;
            n_checks++; if ({ram_if.ram_en_w, ram_if.ram_en_r} !== {p_wacc, p_racc}) begin n_errors++; $display("FAIL rnd_ram_en got %0b exp %0b", {ram_if.ram_en_w, ram_if.ram_en_r}, {p_wacc, p_racc}); end
            n_checks++; if (ram_if.ram_addr_r !== AW'(p_raddr)) begin n_errors++; $display("FAIL rnd_raddr got %0d exp %0d", ram_if.ram_addr_r, p_raddr); end
            tick();
            n_checks++; if (count !== (AW+1)'(q.size())) begin n_errors++; $display("FAIL rnd_count got %0d exp %0d", count, q.size()); end
            n_checks++; if ({full, empty} !== {q.size() == DEPTH, q.size() == 0}) begin n_errors++; $display("FAIL rnd_full_empty got %0b exp %0b", {full, empty}, {q.size() == DEPTH, q.size() == 0}); end
            n_checks++; if ({almost_full, almost_empty} !== {q.size() >= DEPTH - 1, q.size() <= 1}) begin n_errors++; $display("FAIL rnd_almost got %0b at count %0d", {almost_full, almost_empty}, q.size()); end
            n_checks++; if ({rd_valid, overflow, underflow} !== {exp_valid, exp_ovf, exp_udf}) begin n_errors++; $display("FAIL rnd_pulses got %0b exp %0b", {rd_valid, overflow, underflow}, {exp_valid, exp_ovf, exp_udf}); end
            if (exp_valid) begin
                n_checks++; if (rd_data !== exp_data) begin n_errors++; $display("FAIL rnd_data got %0h exp %0h", rd_data, exp_data); end
            end
        end
        while (q.size() > 0) begin
            drive(1'b0, '0, 1'b1);
            tick();
            n_checks++; if (rd_data !== exp_data) begin n_errors++; $display("FAIL rnd_drain got %0h exp %0h", rd_data, exp_data); end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 8'(8'hC0 + i), 1'b0);
            tick();
        end
        drive(1'b0, '0, 1'b1);
        tick();
        drive(1'b0, '0, 1'b0);
        n_checks++; if (count !== (AW+1)'(5) || rd_valid !== 1'b1) begin n_errors++; $display("FAIL mid_pre got %0d/%0b exp 5/1", count, rd_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++; if (count !== '0 || {empty, almost_empty} !== 2'b11) begin n_errors++; $display("FAIL mid_rst_count got %0d/%0b exp 0/11", count, {empty, almost_empty}); end
        n_checks++; if ({full, almost_full, rd_valid, overflow, underflow} !== 5'b0) begin n_errors++; $display("FAIL mid_rst_flags got %0b exp 0", {full, almost_full, rd_valid, overflow, underflow}); end
        #1;
        rst_n = 1'b1;
        tick();
        drive(1'b1, 8'h3C, 1'b0);
        tick();
        drive(1'b0, '0, 1'b1);
        tick();
        n_checks++; if (rd_valid !== 1'b1 || rd_data !== 8'h3C || empty !== 1'b1) begin n_errors++; $display("FAIL mid_new_data got %0h exp 3c", rd_data); end
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        test_reset();
        test_fill_drain();
        test_overflow_underflow();
        test_simultaneous();
        test_wrap();
        test_random();
        test_reset_mid();
        drive(1'b0, '0, 1'b0);
        tick();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_fifo_sync_ctrl
`default_nettype wire
